// File: rtl/mem_boot_loader_pkg.sv
// Shared types and defaults for the BRAM boot loader: FSM state encoding
// and the BRAM depth derived from the byte-address width.
package mem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_D = 3'd1,
        ST_LOAD_I = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4
    } loader_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    // BRAMs are word-organised but byte-addressed, so two address bits are dropped.
    function automatic int depth_words(input int addr_width);
        return 1 << (addr_width - 2);
    endfunction

endpackage

// File: rtl/mem_boot_loader_word_ctr.sv
// Word index counter shared by the data and instruction regions; wraps to
// zero on the handshake that writes the last word of a region.
module loader_word_ctr #(
    parameter int CNT_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 inc,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic [CNT_WIDTH-1:0] index,
    output logic                 last
);

    assign last = (index == (limit - CNT_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
        end else if (clear || (inc && last)) begin
            index <= '0;
        end else if (inc) begin
            index <= index + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_boot_loader.sv
// Boot loader: streams words into the data then instruction BRAM, holds the
// core in stall until both regions are written, then releases it.
module mem_boot_loader
    import mem_boot_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int CNT_WIDTH  = ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  d_count,
    input  logic [CNT_WIDTH-1:0]  i_count,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  d_bram_init_done,
    output logic                  pc_stall,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // One extra bit so a count equal to the depth compares correctly.
    localparam logic [CNT_WIDTH:0] DEPTH = (CNT_WIDTH + 1)'(depth_words(ADDR_WIDTH));

    loader_state_t         state, next_state;
    logic [CNT_WIDTH-1:0]  d_len, i_len;
    logic [CNT_WIDTH-1:0]  index, limit;
    logic                  last;
    logic                  handshake;
    logic                  start_ok;
    logic                  overflow;
    logic                  ctr_clear;
    logic                  ctr_inc;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign s_ready   = (state == ST_LOAD_D) || (state == ST_LOAD_I);
    assign handshake = s_valid && s_ready;
    assign overflow  = ({1'b0, d_count} > DEPTH) || ({1'b0, i_count} > DEPTH);
    assign start_ok  = start && !abort && ((state == ST_IDLE) || (state == ST_RUN));
    assign limit     = (state == ST_LOAD_D) ? d_len : i_len;
    assign ctr_inc   = handshake && !abort;
    assign word_addr = ADDR_WIDTH'({index, 2'b00});

    assign pc_stall         = (state != ST_RUN);
    assign done             = (state == ST_RUN);
    assign busy             = (state == ST_LOAD_D) || (state == ST_LOAD_I) || (state == ST_SETTLE);
    assign d_bram_init_done = (state == ST_LOAD_I) || (state == ST_SETTLE) || (state == ST_RUN);

    loader_word_ctr #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_word_ctr (
        .clk  (clk),
        .rst  (rst),
        .clear(ctr_clear),
        .inc  (ctr_inc),
        .limit(limit),
        .index(index),
        .last (last)
    );

    always_comb begin
        next_state = state;
        ctr_clear  = 1'b0;
        if (abort) begin
            next_state = ST_IDLE;
            ctr_clear  = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (start) begin
                        ctr_clear = 1'b1;
                        if (overflow)            next_state = ST_IDLE;
                        else if (d_count != '0)  next_state = ST_LOAD_D;
                        else if (i_count != '0)  next_state = ST_LOAD_I;
                        else                     next_state = ST_SETTLE;
                    end
                end
                ST_LOAD_D: begin
                    if (handshake && last)
                        next_state = (i_len != '0) ? ST_LOAD_I : ST_SETTLE;
                end
                ST_LOAD_I: begin
                    if (handshake && last) next_state = ST_SETTLE;
                end
                ST_SETTLE: next_state = ST_RUN;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            d_len <= '0;
            i_len <= '0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            if (start_ok) begin
                err <= overflow;
                if (!overflow) begin
                    d_len <= d_count;
                    i_len <= i_count;
                end
            end
        end
    end

    // BRAM ports are registered: each accepted word lands one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_w_enb  <= 1'b0;
            d_w_addr <= '0;
            d_w_dat  <= '0;
            i_w_enb  <= 1'b0;
            i_w_addr <= '0;
            i_w_dat  <= '0;
        end else begin
            d_w_enb <= ctr_inc && (state == ST_LOAD_D);
            i_w_enb <= ctr_inc && (state == ST_LOAD_I);
            if (ctr_inc && (state == ST_LOAD_D)) begin
                d_w_addr <= word_addr;
                d_w_dat  <= s_data;
            end
            if (ctr_inc && (state == ST_LOAD_I)) begin
                i_w_addr <= word_addr;
                i_w_dat  <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Scoreboard bench for mem_boot_loader: expected BRAM writes are queued at
// each handshake and matched against the write ports as they fire.
module tb_mem_boot_loader;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CW = AW - 1;

    typedef struct packed {
        logic          is_data;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] d_count = '0;
    logic [CW-1:0] i_count = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW-1:0] i_w_addr, d_w_addr;
    logic [DW-1:0] i_w_dat, d_w_dat;
    logic          i_w_enb, d_w_enb;
    logic          d_bram_init_done, pc_stall, busy, done, err;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   c0 = 0;
    int   m_d = 0;
    int   k = 0;
    logic mon_on = 1'b0;
    logic exp_en = 1'b0;

    mem_boot_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .d_count         (d_count),
        .i_count         (i_count),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .i_w_addr        (i_w_addr),
        .i_w_dat         (i_w_dat),
        .i_w_enb         (i_w_enb),
        .d_w_addr        (d_w_addr),
        .d_w_dat         (d_w_dat),
        .d_w_enb         (d_w_enb),
        .d_bram_init_done(d_bram_init_done),
        .pc_stall        (pc_stall),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want)
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
        else
            n_pass++;
    endtask

    // A write is expected exactly one cycle after an un-aborted handshake.
    always @(posedge clk) exp_en <= s_valid && s_ready && !abort && !rst;

    always @(negedge clk) begin
        if (mon_on) begin
            checkOutput("one_hot_wen", {31'b0, d_w_enb && i_w_enb}, 32'd0);
            checkOutput("wen_follows_hs", {31'b0, d_w_enb || i_w_enb}, {31'b0, exp_en});
            if (d_w_enb || i_w_enb) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("wr_region", {31'b0, d_w_enb}, {31'b0, mon_e.is_data});
                    checkOutput("wr_addr", {22'b0, d_w_enb ? d_w_addr : i_w_addr}, {22'b0, mon_e.addr});
                    checkOutput("wr_data", d_w_enb ? d_w_dat : i_w_dat, mon_e.dat);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic startLoad(input int d, input int i);
        start   = 1'b1;
        d_count = CW'(d);
        i_count = CW'(i);
        c0      = cyc;
        m_d     = d;
        k       = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input bit toggle);
        int sent = 0;
        int guard = 0;
        int p = 0;
        exp_t e;
        while (sent < n && guard < 500) begin
            s_valid = toggle ? ~p[0] : 1'b1;
            s_data  = 32'h100 + k;
            #1;
            if (s_valid && s_ready) begin
                e.is_data = (k < m_d);
                e.addr    = (k < m_d) ? AW'(k * 4) : AW'((k - m_d) * 4);
                e.dat     = s_data;
                sb.push_back(e);
                k++;
                sent++;
            end
            p++;
            guard++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        checkOutput("send_words", sent, n);
    endtask

    task automatic waitRelease();
        int guard = 0;
        while (!done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("release_done", {31'b0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_pc_stall", {31'b0, pc_stall}, 32'd1);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        checkOutput("rst_s_ready", {31'b0, s_ready}, 32'd0);
        checkOutput("rst_init_done", {31'b0, d_bram_init_done}, 32'd0);
        checkOutput("rst_wen", {30'b0, d_w_enb, i_w_enb}, 32'd0);
        rst    = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        $display("[TB] back-to-back load 10+3");
        startLoad(10, 3);
        checkOutput("load_busy", {31'b0, busy}, 32'd1);
        checkOutput("load_init_low", {31'b0, d_bram_init_done}, 32'd0);
        applyStimulus(13, 1'b0);
        checkOutput("settle_stall", {31'b0, pc_stall}, 32'd1);
        @(negedge clk);
        checkOutput("release_stall", {31'b0, pc_stall}, 32'd0);
        checkOutput("release_done1", {31'b0, done}, 32'd1);

        $display("[TB] toggled-valid load 10+3");
        startLoad(10, 3);
        applyStimulus(13, 1'b1);
        waitRelease();
        checkOutput("toggle_cycles", cyc - c0 + 1, 32'd28);

        $display("[TB] instruction-only load 0+3");
        startLoad(0, 3);
        checkOutput("d0_init_done", {31'b0, d_bram_init_done}, 32'd1);
        checkOutput("d0_s_ready", {31'b0, s_ready}, 32'd1);
        applyStimulus(3, 1'b0);
        checkOutput("d0_settle_stall", {31'b0, pc_stall}, 32'd1);
        @(negedge clk);
        checkOutput("d0_release", {31'b0, pc_stall}, 32'd0);

        $display("[TB] overflow start 257");
        startLoad(257, 3);
        s_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checkOutput("ovf_err", {31'b0, err}, 32'd1);
            checkOutput("ovf_s_ready", {31'b0, s_ready}, 32'd0);
            checkOutput("ovf_pc_stall", {31'b0, pc_stall}, 32'd1);
            checkOutput("ovf_busy", {31'b0, busy}, 32'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        startLoad(2, 0);
        checkOutput("ovf_err_cleared", {31'b0, err}, 32'd0);
        applyStimulus(2, 1'b0);
        waitRelease();

        $display("[TB] abort mid instruction load");
        startLoad(2, 4);
        applyStimulus(4, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        start   = 1'b1;
        abort   = 1'b1;
        d_count = CW'(1);
        i_count = CW'(1);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_pc_stall", {31'b0, pc_stall}, 32'd1);
        checkOutput("abort_init_done", {31'b0, d_bram_init_done}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("abort_s_ready", {31'b0, s_ready}, 32'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;

        $display("[TB] reload from RUN");
        startLoad(1, 1);
        applyStimulus(2, 1'b0);
        waitRelease();
        startLoad(2, 1);
        checkOutput("reload_stall", {31'b0, pc_stall}, 32'd1);
        checkOutput("reload_done", {31'b0, done}, 32'd0);
        applyStimulus(3, 1'b0);
        waitRelease();

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_boot_loader.md
Name: mem_boot_loader

Overview:
Parametrised boot loader that fills the instruction and data BRAMs from a valid/ready word stream, then releases the core. It moves the per-word BRAM initialisation loop into synthesizable RTL, so the rv32i core can be booted on the Zybo Z7-20 without a simulator. It sits between the host stream source (UART/AXI bridge) and the BRAM write ports, PC stall and data-BRAM ownership mux. It adds region sizing, skip-empty-region, overflow rejection, abort and reload.

Parameters:
DATA_WIDTH, 32, stream word and BRAM data width
ADDR_WIDTH, 10, BRAM byte-address width; depth in words = 2**(ADDR_WIDTH-2)
CNT_WIDTH, ADDR_WIDTH-1, word-count width; must hold the depth value

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle load request; sampled only in IDLE or RUN
abort  in  1  return to IDLE and stall the core; has priority over start
d_count  in  CNT_WIDTH  data words to load, latched on accepted start
i_count  in  CNT_WIDTH  instruction words to load, latched on accepted start
s_data  in  DATA_WIDTH  stream word
s_valid  in  1  stream word valid
s_ready  out  1  loader accepts a word this cycle
i_w_addr  out  ADDR_WIDTH  instruction BRAM byte address
i_w_dat  out  DATA_WIDTH  instruction BRAM write data
i_w_enb  out  1  instruction BRAM write enable
d_w_addr  out  ADDR_WIDTH  data BRAM byte address
d_w_dat  out  DATA_WIDTH  data BRAM write data
d_w_enb  out  1  data BRAM write enable
d_bram_init_done  out  1  data BRAM ownership passed to the core
pc_stall  out  1  PC stall
busy  out  1  in LOAD_D, LOAD_I or SETTLE
done  out  1  in RUN
err  out  1  sticky count-overflow flag; cleared by the next accepted start

Behaviour:
- Reset values: state IDLE, pc_stall=1, all other outputs 0, latched counts 0, index 0.
- States are IDLE, LOAD_D, LOAD_I, SETTLE, RUN.
- IDLE/RUN + start:
  - If d_count or i_count exceeds the depth: set err=1, go to (or stay in) IDLE, pc_stall=1, no writes.
  - Otherwise: clear err, latch both counts, index=0, pc_stall=1, d_bram_init_done=0, done=0.
  - Next state is LOAD_D if d_count≠0, else LOAD_I if i_count≠0, else SETTLE.
- LOAD_D / LOAD_I:
  - s_ready=1 combinationally.
  - A handshake (s_valid&&s_ready) in cycle N drives the BRAM port in cycle N+1: w_enb=1, w_addr=index<<2 (zero-extended to ADDR_WIDTH), w_dat=s_data. Write latency is 1 cycle.
  - w_enb is 0 in every cycle that follows no handshake.
  - index increments per handshake. The handshake with index==count-1 resets index to 0 and advances: LOAD_D→LOAD_I (or SETTLE if i_count==0); LOAD_I→SETTLE.
  - s_valid low stalls the FSM indefinitely; there is no timeout.
- d_bram_init_done rises in the cycle LOAD_D is exited, or in the first load cycle when d_count==0. It holds until abort, reset or an accepted start.
- SETTLE: lasts one cycle, so the final BRAM write lands before the core is released. s_ready=0. Then go to RUN.
- RUN: pc_stall=0, done=1, s_ready=0.
- start in RUN reloads: stall reasserts on the next edge. start in LOAD_D, LOAD_I or SETTLE is ignored.
- abort (any state, including mid-load): next cycle is IDLE, pc_stall=1, d_bram_init_done=0, done=0, no write enable, err retained. A partially written BRAM is left as is.
- s_ready is 0 in IDLE, SETTLE and RUN. Stream words offered there are not consumed.
- Exactly one of i_w_enb / d_w_enb may be high in any cycle.

Decomposition:
- DATA_WIDTH default and depth derivation belong in rv32i_params.vh.
- FSM state encodings (3-bit localparams) go in a new include, rv32i_loader.vh.
- One natural sub-module: loader_word_ctr. It holds the index counter with load/clear/increment and a last-word compare, is shared by both regions, and is parametrised by CNT_WIDTH.

Test Plan:
1. Reset, then start with d_count=10, i_count=3 and 13 back-to-back words 0x100+k:
   - d_w_enb pulses at addrs 0x000..0x024 with 0x100..0x109, then i_w_enb at 0x000..0x008 with 0x10A..0x10C.
   - pc_stall falls exactly 2 cycles after the last handshake.
2. Same load with s_valid toggling 1/0:
   - Identical BRAM contents.
   - No w_enb in cycles following s_valid=0.
   - Total cycles = 2×words + 2.
3. d_count=0, i_count=3:
   - No d_w_enb ever.
   - d_bram_init_done=1 from the first load cycle.
   - Core released after 3 words.
4. d_count=257 (depth 256):
   - err=1, stays IDLE, s_ready=0, pc_stall=1, no writes.
   - A following valid start clears err.
5. abort asserted together with start mid-LOAD_I at word 2:
   - Next cycle IDLE, pc_stall=1, d_bram_init_done=0, no further writes.
6. start in RUN:
   - pc_stall=1 and done=0 on the next edge.
   - Reload rewrites from address 0x000.
